// File: rtl/shmem_pkg.sv
// Shared-memory common types and defaults.
// Used by the bank arbiters, the crossbar and the banks.
package shmem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int N_BANKS    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/shmem_bank_arbiter_if.sv
// Lane request/response and bank strobe bundle for one bank arbiter.
// The arbiter uses the slave view; lanes plus bank use the master view.
interface shmem_bank_arbiter_if
    import shmem_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]       resp_data;
    logic                    resp_err;
    logic                    bank_read;
    logic                    bank_write;
    logic [ADDR_W-1:0]       bank_addr;
    logic [DATA_W-1:0]       bank_wdata;
    logic [DATA_W-1:0]       bank_rdata;
    logic                    bank_finish;

    modport slave (
        input  req_valid, req_write, req_addr, req_data,
        input  bank_rdata, bank_finish,
        output req_ready, resp_valid, resp_data, resp_err,
        output bank_read, bank_write, bank_addr, bank_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_data,
        output bank_rdata, bank_finish,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  bank_read, bank_write, bank_addr, bank_wdata
    );

endinterface

// File: rtl/shmem_bank_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational; N_REQ must be a power of two.
module rr_picker #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // Index wraps by truncation since N_REQ is a power of two
            cand = ptr_i + IW'(i);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/shmem_bank_arbiter.sv
// Per-bank front end: round-robin lane arbitration, one bank access
// in flight, response routed back to the winning lane with timeout.
module shmem_bank_arbiter
    import shmem_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TMO_CYC = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    shmem_bank_arbiter_if.slave  bus
);

    localparam int            IW      = $clog2(N_REQ);
    localparam int            TW      = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TMO_CYC);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     lane_q, lane_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rerr_q, rerr_d;

    logic [N_REQ-1:0]  gnt;
    logic [IW-1:0]     gnt_idx;
    logic              accept;
    logic              done;
    logic              expire;

    rr_picker #(.N_REQ(N_REQ)) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign accept = (state_q == ST_IDLE) && (|bus.req_valid);
    assign done   = (state_q == ST_WAIT) && bus.bank_finish;
    assign expire = (state_q == ST_WAIT) && !bus.bank_finish
                    && (tmo_q == TMO_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (done || expire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Ready is gated by reset so nothing looks accepted while held in reset
    always_comb begin
        bus.req_ready  = '0;
        bus.bank_read  = 1'b0;
        bus.bank_write = 1'b0;
        if (state_q == ST_IDLE && reset) bus.req_ready = gnt;
        if (state_q == ST_ISSUE) begin
            bus.bank_read  = !wr_q;
            bus.bank_write = wr_q;
        end
    end

    assign bus.bank_addr  = addr_q;
    assign bus.bank_wdata = wdata_q;
    assign bus.resp_valid = rvalid_q;
    assign bus.resp_data  = rdata_q;
    assign bus.resp_err   = rerr_q;

    always_comb begin
        lane_d   = lane_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rr_ptr_d = rr_ptr_q;
        tmo_d    = tmo_q;
        rvalid_d = '0;
        rdata_d  = '0;
        rerr_d   = 1'b0;
        if (accept) begin
            lane_d  = gnt_idx;
            wr_d    = bus.req_write[gnt_idx];
            addr_d  = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
            wdata_d = bus.req_data[gnt_idx*DATA_W +: DATA_W];
        end
        if (state_q == ST_ISSUE) tmo_d = '0;
        if (state_q == ST_WAIT && !done && !expire) tmo_d = tmo_q + 1'b1;
        if (done || expire) begin
            rvalid_d[lane_q] = 1'b1;
            rdata_d  = (done && !wr_q) ? bus.bank_rdata : '0;
            rerr_d   = expire;
            rr_ptr_d = lane_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            lane_q   <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            tmo_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            lane_q   <= lane_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            tmo_q    <= tmo_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

endmodule

// File: tb/tb_shmem_bank_arbiter.sv
// Scoreboard bench for shmem_bank_arbiter with a 1-cycle bank model.
// Expected responses are queued by stimulus and popped by a monitor.
module tb_shmem_bank_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shmem_bank_arbiter_if #(.N_REQ(4), .ADDR_W(8), .DATA_W(8)) bif ();

    shmem_bank_arbiter #(
        .N_REQ(4), .ADDR_W(8), .DATA_W(8), .TMO_CYC(15)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bif)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Bank model: finish and data one cycle after the strobe
    logic [7:0] mem [256];
    logic       loaded = 1'b0;
    logic       hang   = 1'b0;
    logic       fin_q  = 1'b0;
    logic [7:0] rd_q   = 8'h00;

    always @(posedge clk) begin
        fin_q <= 1'b0;
        rd_q  <= 8'h00;
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h12] <= 8'hA5;
            mem[8'h20] <= 8'hB0;
            mem[8'h21] <= 8'hB1;
            mem[8'h22] <= 8'hB2;
            mem[8'h23] <= 8'hB3;
            loaded <= 1'b1;
        end else begin
            if ((bif.bank_read || bif.bank_write) && !hang) begin
                fin_q <= 1'b1;
                rd_q  <= bif.bank_read ? mem[bif.bank_addr] : 8'hEE;
            end
            if (bif.bank_write) mem[bif.bank_addr] <= bif.bank_wdata;
        end
    end

    assign bif.bank_finish = fin_q;
    assign bif.bank_rdata  = rd_q;

    typedef struct {
        int         lane;
        logic [7:0] data;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   gq[$];
    int   gcyc[$];
    int   last_gnt = 0;
    int   n_gnt[4] = '{0, 0, 0, 0};
    int   n_strobe = 0;

    always @(negedge clk) begin
        if (bif.resp_valid != 4'b0000) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: resp_valid=%b, required none",
                         bif.resp_valid);
            end else begin
                e = sbq.pop_front();
                check("resp_lane", 32'(bif.resp_valid), 32'(1) << e.lane);
                check("resp_data", 32'(bif.resp_data), 32'(e.data));
                check("resp_err", 32'(bif.resp_err), 32'(e.err));
                check("resp_latency", 32'(cyc - last_gnt), 32'(e.lat));
            end
        end
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (bif.req_valid[i] && bif.req_ready[i]) begin
                    n_gnt[i]++;
                    last_gnt = cyc;
                    gq.push_back(i);
                    gcyc.push_back(cyc);
                end
            end
        end
        if (bif.bank_read || bif.bank_write) n_strobe++;
    end

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    task automatic wait_ready(input int lane, input string tag);
        int n = 0;
        @(negedge clk);
        while (!bif.req_ready[lane] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(bif.req_ready), 32'(1) << lane);
    endtask

    task automatic issue(input int lane, input logic wr,
                         input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] ed, input logic ee,
                         input int lat, input string tag);
        sbq.push_back('{lane, ed, ee, lat});
        @(posedge clk); #1;
        bif.req_valid[lane]          = 1'b1;
        bif.req_write[lane]          = wr;
        bif.req_addr[lane*8 +: 8]    = a;
        bif.req_data[lane*8 +: 8]    = d;
        wait_ready(lane, tag);
        @(posedge clk); #1;
        bif.req_valid[lane] = 1'b0;
        @(negedge clk);
        check({tag, "_bank_read"}, 32'(bif.bank_read), 32'(!wr));
        check({tag, "_bank_write"}, 32'(bif.bank_write), 32'(wr));
        check({tag, "_bank_addr"}, 32'(bif.bank_addr), 32'(a));
        if (wr) check({tag, "_bank_wdata"}, 32'(bif.bank_wdata), 32'(d));
        drain();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req_ready"}, 32'(bif.req_ready), 32'd0);
        check({tag, "_resp_valid"}, 32'(bif.resp_valid), 32'd0);
        check({tag, "_resp_data"}, 32'(bif.resp_data), 32'd0);
        check({tag, "_resp_err"}, 32'(bif.resp_err), 32'd0);
        check({tag, "_bank_read"}, 32'(bif.bank_read), 32'd0);
        check({tag, "_bank_write"}, 32'(bif.bank_write), 32'd0);
        check({tag, "_bank_addr"}, 32'(bif.bank_addr), 32'd0);
        check({tag, "_bank_wdata"}, 32'(bif.bank_wdata), 32'd0);
    endtask

    initial begin
        int n;
        int s0;
        int g1;
        int exp_lane[5] = '{0, 1, 2, 3, 0};

        bif.req_valid = 4'hF;
        bif.req_write = 4'h0;
        bif.req_addr  = {8'h23, 8'h22, 8'h21, 8'h20};
        bif.req_data  = 32'h0;

        // Reset state with all lanes already requesting
        repeat (2) @(negedge clk);
        check_quiet("reset");

        // Contention: grants 0,1,2,3,0 three cycles apart
        for (int i = 0; i < 5; i++)
            sbq.push_back('{exp_lane[i], 8'hB0 + 8'(exp_lane[i]), 1'b0, 3});
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        while (gq.size() < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        bif.req_valid = 4'h0;
        check("contention_grants", 32'(gq.size()), 32'd5);
        if (gq.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("contention_lane%0d", i),
                      32'(gq[i]), 32'(exp_lane[i]));
                check($sformatf("contention_gap%0d", i),
                      32'(gcyc[i] - gcyc[0]), 32'(3 * i));
            end
        end
        drain();

        issue(2, 1'b0, 8'h12, 8'h00, 8'hA5, 1'b0, 3, "single_rd");
        issue(0, 1'b1, 8'h80, 8'h3C, 8'h00, 1'b0, 3, "write");
        issue(0, 1'b0, 8'h80, 8'h00, 8'h3C, 1'b0, 3, "read_back");

        // Bank never finishes: response 17 cycles after the strobe
        hang = 1'b1;
        issue(1, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 18, "timeout");
        hang = 1'b0;
        issue(1, 1'b0, 8'h12, 8'h00, 8'hA5, 1'b0, 3, "after_tmo");

        // Lane 1 withdraws before the arbiter returns to IDLE
        s0 = n_strobe;
        g1 = n_gnt[1];
        sbq.push_back('{0, 8'h3C, 1'b0, 3});
        @(posedge clk); #1;
        bif.req_valid[0]     = 1'b1;
        bif.req_write[0]     = 1'b0;
        bif.req_addr[7:0]    = 8'h80;
        wait_ready(0, "withdraw_l0");
        @(posedge clk); #1;
        bif.req_valid[0]     = 1'b0;
        bif.req_valid[1]     = 1'b1;
        bif.req_write[1]     = 1'b0;
        bif.req_addr[15:8]   = 8'h33;
        @(posedge clk); #1;
        bif.req_valid[1]     = 1'b0;
        repeat (10) @(negedge clk);
        check("withdraw_no_grant", 32'(n_gnt[1] - g1), 32'd0);
        check("withdraw_strobes", 32'(n_strobe - s0), 32'd1);
        drain();

        // Reset while in WAIT: access aborted, no response
        hang = 1'b1;
        @(posedge clk); #1;
        bif.req_valid[2]     = 1'b1;
        bif.req_write[2]     = 1'b0;
        bif.req_addr[23:16]  = 8'h12;
        wait_ready(2, "abort_l2");
        @(posedge clk); #1;
        bif.req_valid[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n                = 1'b0;
        bif.req_valid[3]     = 1'b1;
        bif.req_write[3]     = 1'b0;
        bif.req_addr[31:24]  = 8'h23;
        @(negedge clk);
        check_quiet("mid_reset");
        repeat (2) @(negedge clk);
        hang = 1'b0;
        sbq.push_back('{3, 8'hB3, 1'b0, 3});
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 32'(bif.req_ready), 32'h8);
        @(posedge clk); #1;
        bif.req_valid[3] = 1'b0;
        drain();

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required done");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shmem_bank_arbiter.md
# shmem_bank_arbiter

Per-bank front end of the shared memory. It takes up to N_REQ competing lane requests aimed at one 256×8 bank and grants them one at a time in round-robin order. It drives the bank's read/write/address/data strobes, waits for the bank's finish, and routes the read data (or write acknowledge) back to the winning lane. One instance sits directly upstream of each bank.

## Interface
Parameters:
- N_REQ, 4, number of requesting lanes (power of two, ≥2)
- ADDR_W, 8, bank address width
- DATA_W, 8, bank data width
- TMO_CYC, 15, max cycles in WAIT before flagging a bank timeout

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- req_valid  in  N_REQ  per-lane request valid; held stable until accepted
- req_write  in  N_REQ  per-lane: 1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_W  packed per-lane address, lane i at [i*ADDR_W +: ADDR_W]
- req_data  in  N_REQ*DATA_W  packed per-lane write data
- req_ready  out  N_REQ  one-hot acceptance; a request is taken when valid&ready
- resp_valid  out  N_REQ  one-hot, one-cycle response pulse to the owning lane
- resp_data  out  DATA_W  read data for the lane flagged in resp_valid; 0 for writes
- resp_err  out  1  one-cycle pulse alongside resp_valid when the bank timed out
- bank_read  out  1  one-cycle read strobe to the bank
- bank_write  out  1  one-cycle write strobe to the bank
- bank_addr  out  ADDR_W  latched address to the bank
- bank_wdata  out  DATA_W  latched write data to the bank
- bank_rdata  in  DATA_W  bank data_out, valid in the cycle bank_finish is high
- bank_finish  in  1  bank completion flag

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE
  - If any req_valid is set, the round-robin picker chooses lane g.
  - The search starts at rr_ptr and wraps modulo N_REQ.
  - req_ready[g] is asserted combinationally in IDLE only.
  - On acceptance, latch g, write flag, address and data, then go to ISSUE.
- ISSUE
  - Assert exactly one of bank_read/bank_write for one cycle, with bank_addr/bank_wdata stable.
  - Clear the timeout counter and go to WAIT.
- WAIT
  - On bank_finish:
    - register resp_valid[g]=1;
    - resp_data = bank_rdata for a read, 0 for a write;
    - set rr_ptr = (g+1) mod N_REQ;
    - go to IDLE.
  - Otherwise increment the timeout counter. When it reaches TMO_CYC:
    - pulse resp_valid[g] with resp_err=1 and resp_data=0;
    - advance rr_ptr;
    - go to IDLE.
- bank_addr/bank_wdata hold their latched values outside ISSUE; bank_read/bank_write are 0 outside ISSUE.
- Only one outstanding bank access exists at any time. Requests from other lanes wait with valid held.
- A lane may re-request in the same cycle its resp_valid pulses. It is eligible, but sits last in priority.
- A req_valid that drops before acceptance is simply never served; no error is raised.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, latched lane=0, timeout counter=0;
  - req_ready=0, resp_valid=0, resp_data=0, resp_err=0;
  - bank_read=0, bank_write=0, bank_addr=0, bank_wdata=0.
- Reset assertion in ISSUE or WAIT aborts the access with no response. The bank strobes drop asynchronously.
- Latency with the bank's fixed 1-cycle finish:
  - accept at cycle 0;
  - strobe at cycle 1;
  - bank_finish/bank_rdata at cycle 2;
  - resp_valid at cycle 3.
- The arbiter is in IDLE again at cycle 3. A request accepted then gives back-to-back throughput of one access per 3 cycles.
- Timeout response arrives TMO_CYC+2 cycles after the strobe.
- The timeout counter is ceil(log2(TMO_CYC+1)) bits wide and never wraps: it saturates at TMO_CYC.
- Simultaneous requests are resolved solely by rr_ptr. A lane with its valid held is served within N_REQ grants.

## Structure
- Package shmem_pkg:
  - FSM state encoding (IDLE/ISSUE/WAIT);
  - shared ADDR_W/DATA_W defaults;
  - bank count (16) for reuse by the crossbar and banks.
- Sub-module rr_picker (N_REQ): inputs are the request vector and rr_ptr; outputs are the one-hot grant and its index. It is purely combinational. The rest, FSM, latches and timeout, stays in shmem_bank_arbiter.

## Test plan
- Single read:
  - Stimulus: bank preloaded mem[0x12]=0xA5; lane 2 issues a read at 0x12.
  - Required response: req_ready[2] at cycle 0, bank_read at cycle 1 with bank_addr=0x12, resp_valid=4'b0100 with resp_data=0xA5 at cycle 3, resp_err=0.
- Write then read:
  - Stimulus: lane 0 writes 0x3C to 0x80, then lane 0 reads 0x80.
  - Required response: the write response has resp_data=0x00; the read response has resp_data=0x3C.
- Contention:
  - Stimulus: all 4 lanes hold valid from reset.
  - Required response: grant order 0,1,2,3,0. Each grant comes 3 cycles apart and no lane is granted twice before all others.
- Timeout:
  - Stimulus: the bank model never asserts finish; lane 1 issues a read.
  - Required response: resp_valid[1] with resp_err=1 and resp_data=0 arrives 17 cycles after bank_read. The next request is served normally.
- Reset mid-access:
  - Stimulus: drop reset in WAIT, then release it.
  - Required response:
    - while reset is low: all outputs are 0, bank strobes are 0, and no response pulse appears;
    - after release: rr_ptr=0, and a lane 3 request is granted at the first IDLE cycle.
- Withdrawn request:
  - Stimulus: lane 1 raises valid while lane 0 is being served, then drops it before IDLE.
  - Required response: lane 1 is never granted and there is no bank access for it.
